// File: rtl/align_sequencer_if.sv
// Operand-in / aligned-pair-out handshake bundle for the FP alignment sequencer.
interface align_sequencer_if #(
  parameter int ExponentSize = 8,
  parameter int FractionSize = 23
);
  localparam int AlignedWidth = FractionSize + 4;

  logic                    in_vld;
  logic                    in_rdy;
  logic                    sign1;
  logic                    sign2;
  logic [ExponentSize-1:0] exponent1;
  logic [ExponentSize-1:0] exponent2;
  logic [FractionSize-1:0] fraction1;
  logic [FractionSize-1:0] fraction2;

  logic                    out_vld;
  logic                    out_rdy;
  logic                    large_sign;
  logic                    small_sign;
  logic [ExponentSize-1:0] large_exponent;
  logic [AlignedWidth-1:0] large_mantissa;
  logic [AlignedWidth-1:0] small_mantissa;
  logic                    swapped;
  logic                    zero_flag;

  modport master (
    output in_vld, sign1, sign2, exponent1, exponent2, fraction1, fraction2, out_rdy,
    input  in_rdy, out_vld, large_sign, small_sign, large_exponent,
           large_mantissa, small_mantissa, swapped, zero_flag
  );

  modport slave (
    input  in_vld, sign1, sign2, exponent1, exponent2, fraction1, fraction2, out_rdy,
    output in_rdy, out_vld, large_sign, small_sign, large_exponent,
           large_mantissa, small_mantissa, swapped, zero_flag
  );
endinterface

// File: rtl/align_sequencer.sv
// Iterative FP add/sub alignment: orders by exponent, shifts the smaller significand 1 bit/clk with sticky.
// Result valid min(D,AW-1)+1 edges counting the accept edge; DONE holds while out_rdy is low, accepts only in IDLE.
module align_sequencer #(
  parameter int ExponentSize = 8,
  parameter int FractionSize = 23
) (
  input logic              clk,
  input logic              rst,
  align_sequencer_if.slave bus
);
  localparam int AlignedWidth = FractionSize + 4;
  localparam int CountWidth   = $clog2(AlignedWidth);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CountWidth-1:0]   count_q, count_init;
  logic [ExponentSize-1:0] eff1, eff2, diff;
  logic [AlignedWidth-1:0] m1, m2;
  logic                    swap, accept, shift_en;

  logic                    large_sign_q, small_sign_q, swapped_q, zero_flag_q;
  logic [ExponentSize-1:0] large_exponent_q;
  logic [AlignedWidth-1:0] large_mantissa_q, small_mantissa_q;

  // Denormals share the minimum normal exponent; the hidden bit comes from the raw exponent.
  assign eff1 = (bus.exponent1 == '0) ? ExponentSize'(1) : bus.exponent1;
  assign eff2 = (bus.exponent2 == '0) ? ExponentSize'(1) : bus.exponent2;
  assign m1   = {|bus.exponent1, bus.fraction1, 3'b000};
  assign m2   = {|bus.exponent2, bus.fraction2, 3'b000};
  assign swap = eff2 > eff1;
  assign diff = swap ? (eff2 - eff1) : (eff1 - eff2);
  assign count_init = (32'(diff) >= 32'(AlignedWidth - 1)) ? CountWidth'(AlignedWidth - 1)
                                                            : CountWidth'(diff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_vld) begin
          accept  = 1'b1;
          state_d = (count_init != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (count_q == CountWidth'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q          <= '0;
      large_sign_q     <= 1'b0;
      small_sign_q     <= 1'b0;
      swapped_q        <= 1'b0;
      zero_flag_q      <= 1'b0;
      large_exponent_q <= '0;
      large_mantissa_q <= '0;
      small_mantissa_q <= '0;
    end else if (accept) begin
      count_q     <= count_init;
      swapped_q   <= swap;
      zero_flag_q <= (diff == '0);
      if (swap) begin
        large_sign_q     <= bus.sign2;
        small_sign_q     <= bus.sign1;
        large_exponent_q <= bus.exponent2;
        large_mantissa_q <= m2;
        small_mantissa_q <= m1;
      end else begin
        large_sign_q     <= bus.sign1;
        small_sign_q     <= bus.sign2;
        large_exponent_q <= bus.exponent1;
        large_mantissa_q <= m1;
        small_mantissa_q <= m2;
      end
    end else if (shift_en) begin
      // Bit 0 is sticky: it ORs in whatever falls off the bottom and never clears.
      small_mantissa_q <= {1'b0, small_mantissa_q[AlignedWidth-1:2],
                           small_mantissa_q[1] | small_mantissa_q[0]};
      count_q          <= count_q - CountWidth'(1);
    end
  end

  assign bus.in_rdy         = (state_q == IDLE);
  assign bus.out_vld        = (state_q == DONE);
  assign bus.large_sign     = large_sign_q;
  assign bus.small_sign     = small_sign_q;
  assign bus.swapped        = swapped_q;
  assign bus.zero_flag      = zero_flag_q;
  assign bus.large_exponent = large_exponent_q;
  assign bus.large_mantissa = large_mantissa_q;
  assign bus.small_mantissa = small_mantissa_q;
endmodule

// File: tb/tb_align_sequencer.sv
// Directed + random bench for align_sequencer (single precision), scoreboard of expected aligned pairs.
module tb_align_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  align_sequencer_if #(.ExponentSize(8), .FractionSize(23)) bus ();

  align_sequencer #(.ExponentSize(8), .FractionSize(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ls;
    logic        ss;
    logic [7:0]  le;
    logic [26:0] lm;
    logic [26:0] sm;
    logic        sw;
    logic        zf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v)
    else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: shift by n in one step, then fold every discarded bit into the sticky position.
  function automatic exp_t model(input logic s1, input logic s2, input logic [7:0] e1,
                                 input logic [7:0] e2, input logic [22:0] f1, input logic [22:0] f2);
    exp_t        r;
    logic [7:0]  a1, a2, d;
    logic [26:0] ma, mb, small_m, mask;
    int          n;
    a1 = (e1 == 8'd0) ? 8'd1 : e1;
    a2 = (e2 == 8'd0) ? 8'd1 : e2;
    ma = {|e1, f1, 3'b000};
    mb = {|e2, f2, 3'b000};
    r.sw = (a2 > a1);
    if (r.sw) begin
      r.ls = s2; r.ss = s1; r.le = e2; r.lm = mb; small_m = ma; d = a2 - a1;
    end else begin
      r.ls = s1; r.ss = s2; r.le = e1; r.lm = ma; small_m = mb; d = a1 - a2;
    end
    r.zf  = (d == 8'd0);
    n     = (int'(d) > 26) ? 26 : int'(d);
    mask  = (27'(1) << n) - 27'(1);
    r.sm  = small_m >> n;
    if ((small_m & mask) != 27'd0) r.sm[0] = 1'b1;
    r.lat = n + 1;
    return r;
  endfunction

  // Called at posedge+1; leaves the DUT holding its result in DONE.
  task automatic run(input logic s1, input logic s2, input logic [7:0] e1, input logic [7:0] e2,
                     input logic [22:0] f1, input logic [22:0] f2, input string tag, output int lat);
    exp_t e;
    sb.push_back(model(s1, s2, e1, e2, f1, f2));
    chk({tag, ".in_rdy_idle"}, 32'(bus.in_rdy), 32'd1);
    bus.sign1 = s1; bus.sign2 = s2;
    bus.exponent1 = e1; bus.exponent2 = e2;
    bus.fraction1 = f1; bus.fraction2 = f2;
    bus.in_vld = 1'b1;
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
    lat = 1;
    while (bus.out_vld !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
    chk({tag, ".large_sign"}, 32'(bus.large_sign), 32'(e.ls));
    chk({tag, ".small_sign"}, 32'(bus.small_sign), 32'(e.ss));
    chk({tag, ".large_exp"}, 32'(bus.large_exponent), 32'(e.le));
    chk({tag, ".large_mant"}, 32'(bus.large_mantissa), 32'(e.lm));
    chk({tag, ".small_mant"}, 32'(bus.small_mantissa), 32'(e.sm));
    chk({tag, ".swapped"}, 32'(bus.swapped), 32'(e.sw));
    chk({tag, ".zero_flag"}, 32'(bus.zero_flag), 32'(e.zf));
    chk({tag, ".in_rdy_busy"}, 32'(bus.in_rdy), 32'd0);
  endtask

  task automatic release_out(input string tag);
    bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    bus.out_rdy = 1'b0;
    chk({tag, ".out_vld_drop"}, 32'(bus.out_vld), 32'd0);
    chk({tag, ".in_rdy_back"}, 32'(bus.in_rdy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    int   seen;
    exp_t hold_e;

    bus.in_vld = 1'b0; bus.out_rdy = 1'b0;
    bus.sign1 = 1'b0; bus.sign2 = 1'b0;
    bus.exponent1 = '0; bus.exponent2 = '0;
    bus.fraction1 = '0; bus.fraction2 = '0;

    #12;
    chk("reset.in_rdy", 32'(bus.in_rdy), 32'd1);
    chk("reset.out_vld", 32'(bus.out_vld), 32'd0);
    chk("reset.large_mant", 32'(bus.large_mantissa), 32'd0);
    chk("reset.small_mant", 32'(bus.small_mantissa), 32'd0);
    chk("reset.large_exp", 32'(bus.large_exponent), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic two-bit shift.
    run(1'b0, 1'b0, 8'h82, 8'h80, 23'h0, 23'h400000, "basic", lat);
    chk("basic.lat_const", 32'(lat), 32'd3);
    chk("basic.large_mant_const", 32'(bus.large_mantissa), 32'h4000000);
    release_out("basic");

    // Operand 2 has the larger exponent.
    run(1'b1, 1'b0, 8'h7F, 8'h81, 23'h2AAAAA, 23'h155555, "swap", lat);
    chk("swap.swapped_const", 32'(bus.swapped), 32'd1);
    release_out("swap");

    // Sticky collection over 4 and 3 shifts.
    run(1'b0, 1'b0, 8'h84, 8'h80, 23'h123456, 23'h000001, "sticky4", lat);
    chk("sticky4.small_const", 32'(bus.small_mantissa), 32'h0400001);
    release_out("sticky4");
    run(1'b0, 1'b0, 8'h83, 8'h80, 23'h0, 23'h000001, "sticky3", lat);
    chk("sticky3.small_const", 32'(bus.small_mantissa), 32'h0800001);
    release_out("sticky3");

    // Clamp against a denormal: everything collapses into sticky.
    run(1'b0, 1'b1, 8'hFE, 8'h00, 23'h7FFFFF, 23'h000001, "clamp", lat);
    chk("clamp.small_const", 32'(bus.small_mantissa), 32'h0000001);
    chk("clamp.lat_const", 32'(lat), 32'd27);
    release_out("clamp");

    // Equal exponents, then 10 cycles of backpressure with a stray input pulse.
    hold_e = model(1'b0, 1'b1, 8'h90, 8'h90, 23'h0F0F0F, 23'h70F0F0);
    run(1'b0, 1'b1, 8'h90, 8'h90, 23'h0F0F0F, 23'h70F0F0, "equal", lat);
    chk("equal.zero_flag_const", 32'(bus.zero_flag), 32'd1);
    chk("equal.lat_const", 32'(lat), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.exponent1 = 8'h20; bus.exponent2 = 8'h10;
        bus.in_vld = 1'b1;
      end else begin
        bus.in_vld = 1'b0;
      end
      @(posedge clk); #1;
      chk("bp.out_vld", 32'(bus.out_vld), 32'd1);
      chk("bp.in_rdy", 32'(bus.in_rdy), 32'd0);
      chk("bp.small_mant", 32'(bus.small_mantissa), 32'(hold_e.sm));
      chk("bp.large_exp", 32'(bus.large_exponent), 32'(hold_e.le));
    end
    bus.in_vld = 1'b0;
    release_out("equal");
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_vld === 1'b1) seen++;
    end
    chk("bp.stray_not_consumed", 32'(seen), 32'd0);

    // Reset while shifting a D=20 transaction.
    bus.exponent1 = 8'h94; bus.exponent2 = 8'h80;
    bus.fraction1 = 23'h1; bus.fraction2 = 23'h2;
    bus.in_vld = 1'b1;
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_mid.in_rdy", 32'(bus.in_rdy), 32'd1);
    chk("rst_mid.small_mant", 32'(bus.small_mantissa), 32'd0);
    chk("rst_mid.large_mant", 32'(bus.large_mantissa), 32'd0);
    chk("rst_mid.large_exp", 32'(bus.large_exponent), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_vld === 1'b1) seen++;
    end
    chk("rst_mid.no_pulse", 32'(seen), 32'd0);
    run(1'b1, 1'b1, 8'h94, 8'h80, 23'h1, 23'h7FFFFF, "after_rst", lat);
    release_out("after_rst");

    // Random operands across the full exponent range.
    for (int i = 0; i < 8; i++) begin
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          23'($urandom), 23'($urandom), "random", lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      release_out("random");
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
